// File: rtl/div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Shares the start/busy handshake of the iterative multiplier.
module div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_bi,
  input  logic [WIDTH-1:0] b_bi,
  input  logic             start,
  output logic             busy_o,
  output logic [WIDTH-1:0] y_bo,
  output logic [WIDTH-1:0] r_bo,
  output logic             dbz_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             accept;
  logic             last;

  // Remainder stays below the divisor, so its top bit is never needed
  // for the shift; trial sign bit gives the quotient bit.
  assign rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign qbit   = ~trial[WIDTH];
  assign rem_nx = qbit ? trial : rem_sh;
  assign quo_nx = {quo_q[WIDTH-2:0], qbit};

  assign accept = (state_q == IDLE) && start;
  assign last   = (state_q == WORK) && (cnt_q == CW'(WIDTH - 1));
  assign busy_o = (state_q == WORK);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = WORK;
      WORK: if (last)  state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      y_bo  <= '0;
      r_bo  <= '0;
      dbz_o <= 1'b0;
    end else if (accept) begin
      dvd_q <= a_bi;
      dvs_q <= b_bi;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (state_q == WORK) begin
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        y_bo  <= quo_nx;
        r_bo  <= rem_nx[WIDTH-1:0];
        dbz_o <= (dvs_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed and randomized checks for the restoring divider.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_div;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a_bi = '0;
  logic [W-1:0] b_bi = '0;
  logic         start = 1'b0;
  logic         busy_o;
  logic [W-1:0] y_bo;
  logic [W-1:0] r_bo;
  logic         dbz_o;

  int total = 0;
  int bad = 0;

  div #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .a_bi   (a_bi),
    .b_bi   (b_bi),
    .start  (start),
    .busy_o (busy_o),
    .y_bo   (y_bo),
    .r_bo   (r_bo),
    .dbz_o  (dbz_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // Counts busy cycles until busy_o drops, bounded.
  task automatic wait_done(output int len);
    len = 0;
    while (busy_o === 1'b1 && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] ey,
                     input logic [W-1:0] er,
                     input logic edbz);
    int len;
    @(negedge clk);
    a_bi  = a;
    b_bi  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_bi  = $urandom;
    b_bi  = $urandom;
    wait_done(len);
    chk({tag, "_len"}, len, 16);
    chk({tag, "_y"}, y_bo, ey);
    chk({tag, "_r"}, r_bo, er);
    chk({tag, "_dbz"}, dbz_o, edbz);
  endtask

  initial begin
    int len;
    logic [W-1:0] ra, rb;

    // reset, with start asserted to show it is not accepted
    start = 1'b1;
    a_bi  = 16'd77;
    b_bi  = 16'd7;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_y", y_bo, 0);
    chk("rst_r", r_bo, 0);
    chk("rst_dbz", dbz_o, 0);
    start = 1'b0;
    reset = 1'b0;

    run("basic", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    run("max_b1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    run("small", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
    run("msb", 16'h8000, 16'h8000, 16'd1, 16'd0, 1'b0);
    run("dbz", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    run("after_dbz", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

    // start while busy is ignored
    @(negedge clk);
    a_bi  = 16'd50;
    b_bi  = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a_bi  = 16'd1;
    b_bi  = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(len);
    chk("ign_len", len + 4, 16);
    chk("ign_y", y_bo, 10);
    chk("ign_r", r_bo, 0);

    // reset mid-operation
    @(negedge clk);
    a_bi  = 16'd1000;
    b_bi  = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy_pre", busy_o, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy_o, 0);
    chk("mid_y", y_bo, 0);
    chk("mid_r", r_bo, 0);
    chk("mid_dbz", dbz_o, 0);
    reset = 1'b0;
    run("post_rst", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);

    // start held high: back-to-back accepts
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = (i % 10 == 0) ? '0 : W'($urandom >> $urandom_range(0, 31));
      a_bi = ra;
      b_bi = rb;
      @(negedge clk);
      chk("rnd_acc", busy_o, 1);
      wait_done(len);
      chk("rnd_len", len, 16);
      if (rb == 0) begin
        chk("rnd_dbz_y", y_bo, 16'hFFFF);
        chk("rnd_dbz_r", r_bo, ra);
        chk("rnd_dbz", dbz_o, 1);
      end else begin
        chk("rnd_inv", 32'(y_bo) * 32'(rb) + 32'(r_bo), 32'(ra));
        chk("rnd_rlt", 32'(r_bo < rb), 1);
        chk("rnd_dbz0", dbz_o, 0);
      end
    end
    start = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
